// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: n x n unsigned matrix multiply, one MAC per cycle over registered operands.
// Define MATRIX_MAC_SATURATE_EN to clamp each result to the element range instead of wrapping.
module matrix_mac_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM = 4,
  parameter int ACC_WIDTH = 2*DATA_WIDTH + $clog2(MAX_DIM)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [$clog2(MAX_DIM+1)-1:0] cfg_dim,
  input  logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matrix_A,
  input  logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matrix_B,
  output logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matrix_C,
  output logic out_valid,
  input  logic out_ready,
  output logic busy
);
  localparam int CW = $clog2(MAX_DIM+1);
  localparam int IW = $clog2(MAX_DIM);
  localparam int PW = 2*DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] i, j, k, n_m1;
  logic [ACC_WIDTH-1:0] acc, sum;
  logic [PW-1:0] prod;
  logic [DATA_WIDTH-1:0] res;
  logic [CW-1:0] dim;
  always_comb begin
    dim = (cfg_dim == '0 || cfg_dim > CW'(MAX_DIM)) ? CW'(MAX_DIM) : cfg_dim;
    prod = PW'(a_r[i][k]) * PW'(b_r[k][j]);
    sum = acc + ACC_WIDTH'(prod);
`ifdef MATRIX_MAC_SATURATE_EN
    res = (|sum[ACC_WIDTH-1:DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
`else
    res = sum[DATA_WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      matrix_C <= '0;
      acc <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= matrix_A;
          b_r <= matrix_B;
          n_m1 <= IW'(dim - CW'(1));
          matrix_C <= '0;
          acc <= '0;
          i <= '0;
          j <= '0;
          k <= '0;
          state <= CALC;
          in_ready <= 1'b0;
          busy <= 1'b1;
        end
        CALC: if (k == n_m1) begin
          // last term of this dot product: commit it and move to the next element
          matrix_C[i][j] <= res;
          acc <= '0;
          k <= '0;
          if (j == n_m1) begin
            j <= '0;
            if (i == n_m1) begin
              i <= '0;
              state <= DONE;
              out_valid <= 1'b1;
            end else begin
              i <= i + IW'(1);
            end
          end else begin
            j <= j + IW'(1);
          end
        end else begin
          acc <= sum;
          k <= k + IW'(1);
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine: scoreboard bench for matrix_mac_engine at DATA_WIDTH=8, MAX_DIM=4.
module tb_matrix_mac_engine;
  typedef logic [3:0][3:0][7:0] mat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] cfg_dim = '0;
  mat_t matrix_A = '0;
  mat_t matrix_B = '0;
  mat_t matrix_C;
  logic in_ready, out_valid, busy;
  mat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mac_engine #(.DATA_WIDTH(8), .MAX_DIM(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_dim(cfg_dim), .matrix_A(matrix_A), .matrix_B(matrix_B), .matrix_C(matrix_C),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dim_of(input logic [2:0] cfg);
    return (cfg == 3'd0 || cfg > 3'd4) ? 4 : int'(cfg);
  endfunction

  function automatic mat_t model(input mat_t a, input mat_t b, input logic [2:0] cfg);
    mat_t c = '0;
    int n = dim_of(cfg);
    for (int r = 0; r < n; r++)
      for (int q = 0; q < n; q++) begin
        longint s = 0;
        for (int t = 0; t < n; t++) s += longint'(a[r][t]) * longint'(b[t][q]);
`ifdef MATRIX_MAC_SATURATE_EN
        c[r][q] = (s > 255) ? 8'hff : 8'(s);
`else
        c[r][q] = 8'(s);
`endif
      end
    return c;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) m[r][q] = 8'($urandom);
    return m;
  endfunction

  task automatic start_job(input mat_t a, input mat_t b, input logic [2:0] cfg, input bit keep, output mat_t e);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    matrix_A = a;
    matrix_B = b;
    cfg_dim = cfg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    e = model(a, b, cfg);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("done_timeout", 0, 1);
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("q_empty", 1, 0);
      else check("result", matrix_C, exp_q.pop_front());
    end

  initial begin
    mat_t a, b, e, x;
    int lat, n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", in_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_c", matrix_C, 0);
    // 2x2 worked example, garbage outside the active window
    a = rand_mat(); b = rand_mat();
    a[0][0] = 1; a[0][1] = 2; a[1][0] = 3; a[1][1] = 4;
    b[0][0] = 5; b[0][1] = 6; b[1][0] = 7; b[1][1] = 8;
    start_job(a, b, 3'd2, 1'b0, e);
    check("calc_busy", busy, 1);
    check("calc_ready", in_ready, 0);
    wait_done(lat);
    check("lat_2x2", lat, 9);
    x = '0; x[0][0] = 19; x[0][1] = 22; x[1][0] = 43; x[1][1] = 50;
    check("c_2x2", matrix_C, x);
    @(posedge clk); #1;
    // identity times B with cfg_dim=0 selects the full 4x4
    a = '0; for (int r = 0; r < 4; r++) a[r][r] = 1;
    for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) b[r][q] = 8'(4*r + q);
    start_job(a, b, 3'd0, 1'b0, e);
    wait_done(lat);
    check("lat_4x4", lat, 65);
    check("ident", matrix_C, b);
    @(posedge clk); #1;
    a = {16{8'hff}}; b = {16{8'hff}};
    start_job(a, b, 3'd2, 1'b0, e);
    wait_done(lat);
`ifdef MATRIX_MAC_SATURATE_EN
    check("big_00", matrix_C[0][0], 255);
`else
    check("big_00", matrix_C[0][0], 2);
`endif
    check("big_22", matrix_C[2][2], 0);
    @(posedge clk); #1;
    // consumer stall with ignored in_valid pulses
    start_job(rand_mat(), rand_mat(), 3'd2, 1'b0, e);
    out_ready = 1'b0;
    wait_done(lat);
    for (int t = 0; t < 10; t++) begin
      in_valid = t[0];
      matrix_A = rand_mat();
      cfg_dim = 3'd3;
      @(posedge clk); #1;
      check("hold_c", matrix_C, e);
      check("hold_ready", in_ready, 0);
      check("hold_ov", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_ready", in_ready, 1);
    check("post_ov", out_valid, 0);
    check("retain_c", matrix_C, e);
    // reset in the middle of a 4x4 job
    start_job(rand_mat(), rand_mat(), 3'd4, 1'b0, e);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    check("abort_ready", in_ready, 1);
    check("abort_ov", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_c", matrix_C, 0);
    start_job(rand_mat(), rand_mat(), 3'd3, 1'b0, e);
    wait_done(lat);
    check("lat_3x3", lat, 28);
    @(posedge clk); #1;
    // back-to-back with in_valid held; operands change while busy
    start_job(rand_mat(), rand_mat(), 3'd2, 1'b1, e);
    a = rand_mat(); b = rand_mat();
    matrix_A = a; matrix_B = b; cfg_dim = 3'd3;
    wait_done(lat);
    check("b2b_lat1", lat, 9);
    @(posedge clk); #1;
    check("b2b_idle", in_ready, 1);
    exp_q.push_back(model(a, b, 3'd3));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accept", busy, 1);
    wait_done(lat);
    check("b2b_lat2", lat, 28);
    @(posedge clk); #1;
    for (int t = 0; t < 8; t++) begin
      cfg_dim = 3'($urandom_range(0, 7));
      n = dim_of(cfg_dim);
      start_job(rand_mat(), rand_mat(), cfg_dim, 1'b0, e);
      out_ready = 1'($urandom_range(0, 1));
      wait_done(lat);
      check("rand_lat", lat, n*n*n + 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("q_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
